// File: rtl/xor4_lane_recover.sv
// xor4_lane_recover: 3+1 XOR-parity lane recovery with a single output
// register stage, frame-level error accumulation and a parity error counter.
// Optional feature macro: XOR4_LANE_RECOVER_ERRCNT_EN builds ERRCNT/ERR_CLR;
// without it ERRCNT reads 16'h0000 and ERR_CLR is ignored.
//
// Frame FSM
//   state    | meaning
//   IDLE     | between frames (also after a single-beat frame)
//   IN_FRAME | at least one non-last beat of a frame has been accepted
`timescale 1ns/1ps

module xor4_lane_recover (
  input  logic        CLK,
  input  logic        ASYNCRESET,
  input  logic [7:0]  I0,
  input  logic [7:0]  I1,
  input  logic [7:0]  I2,
  input  logic [7:0]  I3,
  input  logic        I_VALID,
  output logic        I_READY,
  input  logic        I_LAST,
  input  logic        ERASE_EN,
  input  logic [1:0]  ERASE,
  output logic [7:0]  O_D0,
  output logic [7:0]  O_D1,
  output logic [7:0]  O_D2,
  output logic        O_VALID,
  input  logic        O_READY,
  output logic        O_PERR,
  output logic        O_LAST,
  output logic        O_FERR,
  output logic        O_BUSY,
  input  logic        ERR_CLR,
  output logic [15:0] ERRCNT
);

  typedef enum logic {IDLE = 1'b0, IN_FRAME = 1'b1} state_t;

  state_t     state;
  logic       acc;
  logic       accept;
  logic [7:0] syn;
  logic [7:0] d0, d1, d2;
  logic       perr;

  // The output stage can take a new beat when it is empty or being drained.
  assign I_READY = !O_VALID | O_READY;
  assign accept  = I_VALID & I_READY;
  assign O_BUSY  = (state == IN_FRAME);

  // Lane recovery: an erased lane equals itself XOR the syndrome, i.e. the
  // XOR of the other three lanes. Parity is not checked on erased beats.
  always_comb begin
    syn  = I0 ^ I1 ^ I2 ^ I3;
    d0   = I0;
    d1   = I1;
    d2   = I2;
    perr = (syn != 8'h00);
    if (ERASE_EN) begin
      perr = 1'b0;
      case (ERASE)
        2'd0:    d0 = I0 ^ syn;
        2'd1:    d1 = I1 ^ syn;
        2'd2:    d2 = I2 ^ syn;
        default: ;
      endcase
    end
  end

  // Frame FSM, error accumulator and the registered output beat.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state   <= IDLE;
      acc     <= 1'b0;
      O_VALID <= 1'b0;
      O_D0    <= 8'h00;
      O_D1    <= 8'h00;
      O_D2    <= 8'h00;
      O_PERR  <= 1'b0;
      O_LAST  <= 1'b0;
      O_FERR  <= 1'b0;
    end else if (accept) begin
      O_VALID <= 1'b1;
      O_D0    <= d0;
      O_D1    <= d1;
      O_D2    <= d2;
      O_PERR  <= perr;
      O_LAST  <= I_LAST;
      O_FERR  <= I_LAST & (acc | perr);
      if (I_LAST) begin
        state <= IDLE;
        acc   <= 1'b0;
      end else begin
        state <= IN_FRAME;
        acc   <= acc | perr;
      end
    end else if (O_READY) begin
      O_VALID <= 1'b0;
    end
  end

`ifdef XOR4_LANE_RECOVER_ERRCNT_EN
  logic [15:0] errcnt;

  // Saturating count of accepted parity-error beats; clear has priority.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      errcnt <= 16'h0000;
    end else if (ERR_CLR) begin
      errcnt <= 16'h0000;
    end else if (accept && perr && (errcnt != 16'hFFFF)) begin
      errcnt <= errcnt + 16'd1;
    end
  end

  assign ERRCNT = errcnt;
`else
  logic unused_err_clr;
  assign unused_err_clr = ERR_CLR;
  assign ERRCNT         = 16'h0000;
`endif

endmodule

// File: tb/tb_xor4_lane_recover.sv
// Self-checking bench for xor4_lane_recover: a reference model computes each
// expected output beat at acceptance and queues it; a monitor pops and
// compares on every delivery. Scenario tasks check status outputs inline.
`timescale 1ns/1ps

module tb_xor4_lane_recover;

  logic        CLK = 1'b0;
  logic        ASYNCRESET;
  logic [7:0]  I0, I1, I2, I3;
  logic        I_VALID, I_READY, I_LAST, ERASE_EN;
  logic [1:0]  ERASE;
  logic [7:0]  O_D0, O_D1, O_D2;
  logic        O_VALID, O_READY, O_PERR, O_LAST, O_FERR, O_BUSY;
  logic        ERR_CLR;
  logic [15:0] ERRCNT;

`ifdef XOR4_LANE_RECOVER_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] d2;
    logic       perr;
    logic       last;
    logic       ferr;
  } beat_t;

  beat_t       sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          last_wait;
  logic        m_acc, m_busy;
  logic [15:0] m_errcnt;

  xor4_lane_recover dut (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET),
    .I0(I0), .I1(I1), .I2(I2), .I3(I3),
    .I_VALID(I_VALID), .I_READY(I_READY), .I_LAST(I_LAST),
    .ERASE_EN(ERASE_EN), .ERASE(ERASE),
    .O_D0(O_D0), .O_D1(O_D1), .O_D2(O_D2),
    .O_VALID(O_VALID), .O_READY(O_READY),
    .O_PERR(O_PERR), .O_LAST(O_LAST), .O_FERR(O_FERR), .O_BUSY(O_BUSY),
    .ERR_CLR(ERR_CLR), .ERRCNT(ERRCNT)
  );

  always #5 CLK = ~CLK;

  // Delivery monitor: a beat is delivered at the next rising edge.
  always @(negedge CLK) begin
    if (!ASYNCRESET && O_VALID && O_READY) begin
      beat_t act, exp;
      act = {O_D0, O_D1, O_D2, O_PERR, O_LAST, O_FERR};
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_extra_beat actual=%h required=none", act);
      end else begin
        exp = sb_q.pop_front();
        if (act !== exp) begin
          n_bad++;
          $display("FAIL sb_beat actual=%h required=%h", act, exp);
        end
      end
    end
  end

  // Drive one beat, wait (bounded) for acceptance, model it and queue the result.
  task automatic send(input logic [7:0] a, b, c, p, input logic last, een,
                      input logic [1:0] er, input logic clr);
    int         n;
    logic [7:0] ln [4];
    logic [7:0] x;
    logic       perr;
    beat_t      e;
    I0 = a; I1 = b; I2 = c; I3 = p;
    I_VALID = 1'b1; I_LAST = last; ERASE_EN = een; ERASE = er; ERR_CLR = clr;
    n = 0;
    @(negedge CLK);
    while (!I_READY && n < 100) begin
      @(negedge CLK);
      n++;
    end
    last_wait = n;
    if (!I_READY) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout actual=I_READY=0 required=I_READY=1");
    end else begin
      ln[0] = a; ln[1] = b; ln[2] = c; ln[3] = p;
      e.d0 = a; e.d1 = b; e.d2 = c;
      if (een) begin
        perr = 1'b0;
        if (er != 2'd3) begin
          x = 8'h00;
          for (int j = 0; j < 4; j++) if (j != int'(er)) x ^= ln[j];
          case (er)
            2'd0: e.d0 = x;
            2'd1: e.d1 = x;
            default: e.d2 = x;
          endcase
        end
      end else begin
        perr = ((a ^ b ^ c ^ p) != 8'h00);
      end
      e.perr = perr;
      e.last = last;
      e.ferr = last & (m_acc | perr);
      if (last) begin m_acc = 1'b0; m_busy = 1'b0; end
      else begin m_acc = m_acc | perr; m_busy = 1'b1; end
      if (CNT_EN) begin
        if (clr) m_errcnt = 16'h0000;
        else if (perr && m_errcnt != 16'hFFFF) m_errcnt = m_errcnt + 16'd1;
      end
      sb_q.push_back(e);
    end
    @(posedge CLK);
    #1;
    I_VALID = 1'b0;
    ERR_CLR = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain actual=%0d_pending required=0_pending", tag, sb_q.size());
      sb_q.delete();
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    ASYNCRESET = 1'b1;
    I0 = 0; I1 = 0; I2 = 0; I3 = 0; I_VALID = 0; I_LAST = 0;
    ERASE_EN = 0; ERASE = 0; O_READY = 1; ERR_CLR = 0;
    m_acc = 0; m_busy = 0; m_errcnt = 0;
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++;
    if ({O_VALID, O_D0, O_D1, O_D2, O_PERR, O_LAST, O_FERR, O_BUSY, ERRCNT} !== 45'd0) begin
      n_bad++;
      $display("FAIL reset_outputs actual=%h required=0",
               {O_VALID, O_D0, O_D1, O_D2, O_PERR, O_LAST, O_FERR, O_BUSY, ERRCNT});
    end
    @(negedge CLK);
    ASYNCRESET = 1'b0;
    @(posedge CLK);
    #1;
    n_cmp++;
    if (I_READY !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_i_ready actual=%b required=1", I_READY);
    end
  endtask

  task automatic test_good_beat();
    send(8'h12, 8'h34, 8'h56, 8'h70, 1'b1, 1'b0, 2'd0, 1'b0);
    n_cmp++;
    if ({O_VALID, O_D0, O_D1, O_D2, O_PERR} !== {1'b1, 8'h12, 8'h34, 8'h56, 1'b0}) begin
      n_bad++;
      $display("FAIL good_beat actual=%h required=%h",
               {O_VALID, O_D0, O_D1, O_D2, O_PERR}, {1'b1, 8'h12, 8'h34, 8'h56, 1'b0});
    end
    drain("good_beat");
  endtask

  task automatic test_erasure();
    logic [7:0] a, b, c, p;
    send(8'h12, 8'hFF, 8'h56, 8'h70, 1'b1, 1'b1, 2'd1, 1'b0);
    n_cmp++;
    if ({O_D1, O_PERR} !== {8'h34, 1'b0}) begin
      n_bad++;
      $display("FAIL erasure_lane1 actual=%h required=%h", {O_D1, O_PERR}, {8'h34, 1'b0});
    end
    for (int i = 0; i < 32; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      c = 8'($urandom_range(0, 255));
      p = a ^ b ^ c;
      if ($urandom_range(0, 1) == 1) p = p ^ 8'($urandom_range(1, 255));
      send(a, b, c, p, 1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0);
    end
    drain("erasure");
  endtask

  task automatic test_frame();
    send(8'h01, 8'h02, 8'h03, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1);
    n_cmp++;
    if (O_BUSY !== 1'b1) begin
      n_bad++;
      $display("FAIL frame_busy_b1 actual=%b required=1", O_BUSY);
    end
    send(8'h10, 8'h20, 8'h30, 8'h01, 1'b0, 1'b0, 2'd0, 1'b0);
    send(8'hAA, 8'h55, 8'hFF, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);
    n_cmp++;
    if ({O_BUSY, O_LAST, O_FERR} !== 3'b011) begin
      n_bad++;
      $display("FAIL frame_end actual=%b required=011", {O_BUSY, O_LAST, O_FERR});
    end
    n_cmp++;
    if (ERRCNT !== (CNT_EN ? 16'd1 : 16'd0)) begin
      n_bad++;
      $display("FAIL frame_errcnt actual=%h required=%h", ERRCNT, CNT_EN ? 16'd1 : 16'd0);
    end
    drain("frame");
  endtask

  task automatic test_backpressure();
    O_READY = 1'b0;
    send(8'h11, 8'h22, 8'h33, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
    I0 = 8'h44; I1 = 8'h55; I2 = 8'h66; I3 = 8'h77; I_LAST = 1'b1; I_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      n_cmp++;
      if ({I_READY, O_VALID, O_D0, O_D1, O_D2, O_LAST} !== {1'b0, 1'b1, 8'h11, 8'h22, 8'h33, 1'b0}) begin
        n_bad++;
        $display("FAIL bp_hold cycle=%0d actual=%h required=%h", i,
                 {I_READY, O_VALID, O_D0, O_D1, O_D2, O_LAST},
                 {1'b0, 1'b1, 8'h11, 8'h22, 8'h33, 1'b0});
      end
    end
    @(posedge CLK);
    #1;
    O_READY = 1'b1;
    send(8'h44, 8'h55, 8'h66, 8'h77, 1'b1, 1'b0, 2'd0, 1'b0);
    drain("backpressure");
  endtask

  task automatic test_back_to_back();
    int  stalls;
    bit  done;
    logic [7:0] a, b, c;
    stalls = 0;
    O_READY = 1'b1;
    for (int i = 0; i < 12; i++) begin
      a = 8'(i * 3); b = 8'(i * 5); c = 8'(i * 7);
      send(a, b, c, a ^ b ^ c ^ ((i == 5) ? 8'h80 : 8'h00), 1'((i % 4) == 3), 1'b0, 2'd0, 1'b0);
      if (last_wait != 0) stalls++;
    end
    n_cmp++;
    if (stalls !== 0) begin
      n_bad++;
      $display("FAIL b2b_throughput actual=%0d_stalls required=0_stalls", stalls);
    end
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
          c = 8'($urandom_range(0, 255));
          send(a, b, c, a ^ b ^ c ^ 8'($urandom_range(0, 1)), 1'((i % 3) == 2),
               1'b0, 2'd0, 1'b0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge CLK);
          #2;
          O_READY = 1'($urandom_range(0, 1));
        end
      end
    join
    O_READY = 1'b1;
    drain("b2b");
  endtask

  task automatic test_saturation();
`ifdef XOR4_LANE_RECOVER_ERRCNT_EN
    send(8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 65537; i++)
      send(8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0, 2'd0, 1'b0);
    n_cmp++;
    if (ERRCNT !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL sat_errcnt actual=%h required=ffff", ERRCNT);
    end
`else
    send(8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0, 2'd0, 1'b0);
`endif
    n_cmp++;
    if (ERRCNT !== m_errcnt) begin
      n_bad++;
      $display("FAIL sat_model actual=%h required=%h", ERRCNT, m_errcnt);
    end
    send(8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0, 2'd0, 1'b1);
    n_cmp++;
    if (ERRCNT !== 16'h0000) begin
      n_bad++;
      $display("FAIL clr_errcnt actual=%h required=0000", ERRCNT);
    end
    drain("saturation");
  endtask

  task automatic test_reset_midframe();
    O_READY = 1'b0;
    send(8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 1'b0, 2'd0, 1'b0);
    #2;
    ASYNCRESET = 1'b1;
    #1;
    n_cmp++;
    if ({O_VALID, O_D0, O_D1, O_D2, O_PERR, O_LAST, O_FERR, O_BUSY, ERRCNT} !== 45'd0) begin
      n_bad++;
      $display("FAIL midreset_outputs actual=%h required=0",
               {O_VALID, O_D0, O_D1, O_D2, O_PERR, O_LAST, O_FERR, O_BUSY, ERRCNT});
    end
    sb_q.delete();
    m_acc = 0; m_busy = 0; m_errcnt = 0;
    O_READY = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    ASYNCRESET = 1'b0;
    @(posedge CLK);
    #1;
    n_cmp++;
    if (I_READY !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_i_ready actual=%b required=1", I_READY);
    end
    send(8'h12, 8'h34, 8'h56, 8'h70, 1'b1, 1'b0, 2'd0, 1'b0);
    n_cmp++;
    if ({O_VALID, O_LAST, O_FERR, O_BUSY} !== 4'b1100) begin
      n_bad++;
      $display("FAIL midreset_frame actual=%b required=1100", {O_VALID, O_LAST, O_FERR, O_BUSY});
    end
    drain("midreset");
  endtask

  initial begin
    test_reset();
    test_good_beat();
    test_erasure();
    test_frame();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/xor4_lane_recover.md
XOR4_LANE_RECOVER -- requirements
Module: xor4_lane_recover

Interface
REQ-001 Parameters: none; all data lanes are fixed at 8 bits.
REQ-002 CLK  input  1  sole clock; all state changes on the rising edge.
REQ-003 ASYNCRESET  input  1  asynchronous, active-high reset.
REQ-004 I0, I1, I2  input  8  data lanes 0..2 of an input beat.
REQ-005 I3  input  8  parity lane of an input beat; I0^I1^I2^I3 == 0 for a good beat.
REQ-006 I_VALID  input  1  input beat present.
REQ-007 I_READY  output  1  block accepts the beat this cycle.
REQ-008 I_LAST  input  1  beat is the last beat of a frame.
REQ-009 ERASE_EN  input  1  one lane of this beat is known bad and is rebuilt.
REQ-010 ERASE  input  2  index (0..3) of the erased lane; ignored when ERASE_EN=0.
REQ-011 O_D0, O_D1, O_D2  output  8  recovered data lanes.
REQ-012 O_VALID  output  1  output beat present.
REQ-013 O_READY  input  1  downstream accepts the output beat.
REQ-014 O_PERR  output  1  parity mismatch on this beat.
REQ-015 O_LAST  output  1  registered copy of I_LAST.
REQ-016 O_FERR  output  1  frame error, meaningful only when O_LAST=1.
REQ-017 O_BUSY  output  1  frame state is IN_FRAME.
REQ-018 ERR_CLR  input  1  synchronous clear of ERRCNT.
REQ-019 ERRCNT  output  16  count of beats accepted with parity error.

Function
REQ-020 A beat is accepted when I_VALID=1 and I_READY=1, and is delivered when O_VALID=1 and O_READY=1.
REQ-021 I_READY = !O_VALID | O_READY, combinational; the block has a single output register stage.
REQ-022 Latency from acceptance to O_VALID is exactly 1 cycle; back-to-back beats sustain 1 beat per cycle while O_READY=1.
REQ-023 While O_VALID=1 and O_READY=0, all O_* outputs hold stable.
REQ-024 O_VALID clears after a delivery in a cycle with no acceptance.
REQ-025 Syndrome S = I0^I1^I2^I3, computed bitwise.
REQ-026 When ERASE_EN=0: O_Dk = Ik, and O_PERR = (S != 0).
REQ-027 When ERASE_EN=1 and ERASE=k with k in 0..2: O_Dk = XOR of the three other input lanes, the other data lanes pass through unchanged, and O_PERR = 0.
REQ-028 When ERASE_EN=1 and ERASE=3: data lanes pass through unchanged and O_PERR = 0.
REQ-029 Frame FSM states are IDLE and IN_FRAME.
 - IDLE -> IN_FRAME on an accepted beat with I_LAST=0.
 - IN_FRAME -> IDLE on an accepted beat with I_LAST=1.
 - An accepted beat with I_LAST=1 while in IDLE is a single-beat frame; the FSM stays in IDLE.
REQ-030 The frame error accumulator ORs PERR over every accepted beat of the frame and clears on acceptance of the I_LAST beat.
REQ-031 O_FERR = accumulator | PERR of the last beat when O_LAST=1; otherwise O_FERR = 0.
REQ-032 ERRCNT increments by 1 per accepted beat with PERR=1 and saturates at 16'hFFFF.
REQ-033 When ERR_CLR=1 and an increment occur in the same cycle, clear wins and ERRCNT = 0.

Reset
REQ-034 While ASYNCRESET=1, and immediately on its assertion, the block drives:
 - O_VALID=0, O_D0/O_D1/O_D2=8'h00
 - O_PERR=0, O_LAST=0, O_FERR=0
 - FSM=IDLE, O_BUSY=0, accumulator=0, ERRCNT=0
REQ-035 Reset asserted mid-frame or with a stalled output beat discards that beat, and the next frame starts fresh.
REQ-036 I_READY=1 in the first cycle after reset deasserts.

Configuration
REQ-037 Macro XOR4_LANE_RECOVER_ERRCNT_EN: when defined, the ERRCNT counter and ERR_CLR logic are built.
REQ-038 When XOR4_LANE_RECOVER_ERRCNT_EN is undefined, the ERRCNT port remains, is driven 16'h0000, and ERR_CLR is ignored; all other behaviour is identical.

Verification
REQ-039 Good beat: I0=8'h12, I1=8'h34, I2=8'h56, I3=8'h70, ERASE_EN=0 -> next cycle O_VALID=1, O_D0..O_D2 = 12/34/56, O_PERR=0.
REQ-040 Erasure: same beat with I1=8'hFF, ERASE_EN=1, ERASE=1 -> O_D1=8'h34, O_PERR=0.
REQ-041 Frame of 3 beats with a bad parity lane on beat 2 only -> O_FERR=1 on beat 3, O_BUSY falls after beat 3 is accepted, ERRCNT=1.
REQ-042 Backpressure: O_READY=0 for 4 cycles with I_VALID=1 -> one beat held stable, I_READY=0, and no beat lost or duplicated once released.
REQ-043 Saturation: force 65537 bad beats -> ERRCNT=16'hFFFF; ERR_CLR together with a bad beat -> ERRCNT=0.
REQ-044 ASYNCRESET pulsed mid-frame with O_VALID=1 -> all outputs return to reset values with no clock edge; a following single-beat good frame gives O_FERR=0.
